// File: rtl/ercm_pipe.sv
// Two-stage pipelined error-recovery carry-free multiplier: an OR tree of partial products
// plus collected AND error terms gives exact, approximate or OR-only products.
module ercm_pipe #(
  parameter int unsigned N     = 8,
  parameter int unsigned TRUNC = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  input  logic           cnt_clr,
  output logic [15:0]    err_cnt
);

  localparam int unsigned W2   = 2 * N;
  localparam int unsigned Lvls = $clog2(N);

  localparam logic [1:0] ModeApprox = 2'b01;
  localparam logic [1:0] ModeOrOnly = 2'b10;

  // Combinational tree on the incoming operands
  logic [W2-1:0] w_s;
  logic [W2-1:0] w_v;
  logic [W2-1:0] w_sum;

  // Stage 1
  logic          r_s1_valid;
  logic [W2-1:0] r_s1_s;
  logic [W2-1:0] r_s1_v;
  logic [W2-1:0] r_s1_sum;
  logic [1:0]    r_s1_mode;

  // Stage 2
  logic          r_s2_valid;
  logic [W2-1:0] r_s2_p;
  logic          r_s2_mis;

  logic [15:0]   r_err_cnt;

  logic          w_s1_load;
  logic          w_s2_load;
  logic [W2-1:0] w_exact;
  logic [W2-1:0] w_vtrunc;
  logic [W2-1:0] w_res;
  logic          w_mis;

  // Node j of each level is rebuilt in place from nodes 2j and 2j+1 of the level below.
  always_comb begin : tree
    logic [W2-1:0] w_node [N];
    logic [W2-1:0] w_e;
    w_v   = '0;
    w_sum = '0;
    w_e   = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_node[i] = in_a[i] ? (W2'(in_b) << i) : '0;
    end
    for (int l = 1; l <= int'(Lvls); l++) begin
      for (int j = 0; j < int'(N >> l); j++) begin
        w_e       = w_node[2*j] & w_node[2*j+1];
        w_node[j] = w_node[2*j] | w_node[2*j+1];
        w_v       = w_v | w_e;
        w_sum     = w_sum + w_e;
      end
    end
    w_s = w_node[0];
  end

  always_comb begin
    w_vtrunc = '0;
    for (int k = 0; k < int'(W2); k++) begin
      w_vtrunc[k] = (k >= int'(TRUNC)) ? r_s1_v[k] : 1'b0;
    end
    w_exact = r_s1_s + r_s1_sum;
    case (r_s1_mode)
      ModeApprox: w_res = r_s1_s + w_vtrunc;
      ModeOrOnly: w_res = r_s1_s;
      default:    w_res = w_exact;
    endcase
    w_mis = (w_res != w_exact);
  end

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_s     <= '0;
      r_s1_v     <= '0;
      r_s1_sum   <= '0;
      r_s1_mode  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_p     <= '0;
      r_s2_mis   <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_s    <= w_s;
          r_s1_v    <= w_v;
          r_s1_sum  <= w_sum;
          r_s1_mode <= in_mode;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_p   <= w_res;
          r_s2_mis <= w_mis;
        end
      end
      // Clear wins over a same-cycle mismatch handshake
      if (cnt_clr) begin
        r_err_cnt <= '0;
      end else if (r_s2_valid && out_ready && r_s2_mis && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_valid;
  assign out_p     = r_s2_p;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ercm_pipe.sv
// Self-checking bench for ercm_pipe (N=8, TRUNC=4): transaction-level model with a
// per-cycle compare process plus directed literal checks.
module tb_ercm_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_p;
  logic        cnt_clr = 1'b0;
  logic [15:0] err_cnt;

  ercm_pipe #(.N(8), .TRUNC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .cnt_clr   (cnt_clr),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_deliv = 0;
  bit mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Returns {mismatch, product}. S is the OR of all partial products; every tree node
  // over an aligned power-of-two block contributes OR(left half) & OR(right half) to V.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] m);
    logic [15:0] g [8];
    logic [15:0] s, v, lo, hi, exact, p;
    s = '0;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      g[i] = a[i] ? (16'(b) << i) : 16'h0;
      s    = s | g[i];
    end
    for (int sz = 2; sz <= 8; sz = sz * 2) begin
      for (int st = 0; st < 8; st = st + sz) begin
        lo = '0;
        hi = '0;
        for (int k = 0; k < sz / 2; k++) begin
          lo = lo | g[st + k];
          hi = hi | g[st + sz / 2 + k];
        end
        v = v | (lo & hi);
      end
    end
    exact = 16'(a) * 16'(b);
    case (m)
      2'b01:   p = s + (v & 16'hFFF0);
      2'b10:   p = s;
      default: p = exact;
    endcase
    return {p != exact, p};
  endfunction

  typedef struct {
    logic [15:0] p;
    bit          mis;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_err = '0;

  // Values at negedge are what the next rising edge samples.
  always @(negedge clk) begin
    if (mon_en) begin
      bit          exp_rdy, exp_ov;
      logic [16:0] r;
      exp_t        e;
      exp_rdy = (q.size() < 2) || out_ready;
      exp_ov  = (q.size() > 0) && (cyc >= q[0].acc + 2);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) chk("out_p", 32'(out_p), 32'(q[0].p));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      if (rst) begin
        q.delete();
        m_err = '0;
      end else begin
        if (cnt_clr) m_err = '0;
        else if (exp_ov && out_ready && q[0].mis && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        if (exp_ov && out_ready) begin
          void'(q.pop_front());
          n_deliv++;
        end
        if (in_valid && exp_rdy) begin
          r     = model(in_a, in_b, in_mode);
          e.p   = r[15:0];
          e.mis = r[16];
          e.acc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one transaction and return just after its accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    bit ok;
    int t;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 50) begin
      #1;
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          base, acc_n, t, idx;
    bit          saw_low, ok;
    logic [7:0]  sa [6];
    logic [7:0]  sb [6];
    logic [1:0]  sm [6];

    sa = '{8'h12, 8'h56, 8'h9A, 8'hDE, 8'h33, 8'hFF};
    sb = '{8'h34, 8'h78, 8'hBC, 8'hF0, 8'h33, 8'h01};
    sm = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};

    // Reset state
    @(posedge clk);
    mon_en = 1'b1;
    step(1);
    chk("rst_out_p", 32'(out_p), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    step(1);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Pin the model against hand-derived values
    chk("model_ff_exact", 32'(model(8'hFF, 8'hFF, 2'b00)), 32'h0FE01);
    chk("model_33_approx", 32'(model(8'h33, 8'h33, 2'b01)), 32'h109E7);
    chk("model_30_approx", 32'(model(8'h30, 8'h30, 2'b01)), 32'h00900);
    chk("model_30_or", 32'(model(8'h30, 8'h30, 2'b10)), 32'h10700);

    // Exact 0xFF*0xFF
    send(8'hFF, 8'hFF, 2'b00);
    step(1);
    chk("ff_valid", 32'(out_valid), 32'h1);
    chk("ff_p", 32'(out_p), 32'hFE01);
    step(1);
    chk("ff_err", 32'(err_cnt), 32'h0);

    // Approximate 0x33*0x33
    send(8'h33, 8'h33, 2'b01);
    step(1);
    chk("33_p", 32'(out_p), 32'h09E7);
    step(1);
    chk("33_err", 32'(err_cnt), 32'h1);

    // 0x30*0x30 approximate (exact) then OR-only (mismatch)
    send(8'h30, 8'h30, 2'b01);
    step(1);
    chk("30a_p", 32'(out_p), 32'h0900);
    step(1);
    chk("30a_err", 32'(err_cnt), 32'h1);
    send(8'h30, 8'h30, 2'b10);
    step(1);
    chk("30o_p", 32'(out_p), 32'h0700);
    step(1);
    chk("30o_err", 32'(err_cnt), 32'h2);

    // Six back-to-back with a 3-cycle stall
    base    = n_deliv;
    saw_low = 1'b0;
    idx     = 0;
    t       = 0;
    while (idx < 6 && t < 100) begin
      in_valid  = 1'b1;
      in_a      = sa[idx];
      in_b      = sb[idx];
      in_mode   = sm[idx];
      out_ready = !(t >= 3 && t < 6);
      #1;
      ok = in_ready;
      if (!ok) saw_low = 1'b1;
      @(posedge clk);
      #1;
      if (ok) idx++;
      t++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(6);
    chk("stream_ready_dropped", 32'(saw_low), 32'h1);
    chk("stream_delivered", 32'(n_deliv - base), 32'd6);

    // Saturation of err_cnt
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_err", 32'(err_cnt), 32'h0);
    in_valid = 1'b1;
    in_a     = 8'h30;
    in_b     = 8'h30;
    in_mode  = 2'b10;
    acc_n    = 0;
    t        = 0;
    while (acc_n < 65535 && t < 70000) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) acc_n++;
      t++;
    end
    in_valid = 1'b0;
    step(4);
    chk("sat_preload", 32'(err_cnt), 32'hFFFF);
    send(8'h30, 8'h30, 2'b10);
    step(3);
    chk("sat_hold", 32'(err_cnt), 32'hFFFF);
    out_ready = 1'b0;
    send(8'h30, 8'h30, 2'b10);
    step(1);
    chk("clr_race_valid", 32'(out_valid), 32'h1);
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_race_err", 32'(err_cnt), 32'h0);
    chk("clr_race_taken", 32'(out_valid), 32'h0);

    // Reset with both stages occupied
    send(8'h30, 8'h30, 2'b10);
    step(3);
    chk("pre_rst_err", 32'(err_cnt), 32'h1);
    out_ready = 1'b0;
    send(8'h33, 8'h33, 2'b01);
    send(8'hFF, 8'h0F, 2'b10);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_err", 32'(err_cnt), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
    base      = n_deliv;
    out_ready = 1'b1;
    step(5);
    chk("no_stale_valid", 32'(out_valid), 32'h0);
    chk("no_stale_deliv", 32'(n_deliv - base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ercm_pipe.md
ERCM_PIPE -- requirements
Module: ercm_pipe

Interface
REQ-001 SHALL have parameter N, default 8, operand width; legal values 4, 8, 16.
REQ-002 SHALL have parameter TRUNC, default 4, count of low error columns discarded in approximate mode; legal range 0..2N.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand transaction offered.
REQ-006 SHALL have port in_ready  output  1  block accepts the offered transaction this cycle.
REQ-007 SHALL have port in_a  input  N  multiplicand, unsigned.
REQ-008 SHALL have port in_b  input  N  multiplier, unsigned.
REQ-009 SHALL have port in_mode  input  2  00 exact, 01 approximate, 10 OR-only, 11 treated as exact.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port out_p  output  2N  product for the transaction's mode.
REQ-013 SHALL have port cnt_clr  input  1  synchronous clear of err_cnt.
REQ-014 SHALL have port err_cnt  output  16  saturating count of delivered results differing from the exact product.

Function
REQ-015 Partial products SHALL be G[i] = (in_a[i] ? in_b : 0) << i, 2N bits, i = 0..N-1.
REQ-016 Tree level l (1..log2 N) SHALL form node j as OR = G[2j] | G[2j+1] and error term E = G[2j] & G[2j+1] (aligned, same column weight), where G refers to level l-1 node values.
REQ-017 S SHALL be the root OR value; V SHALL be the bitwise OR of every error term E in the tree; SUM_E SHALL be the arithmetic sum of every E.
REQ-018 Exact result SHALL be S + SUM_E, equal to in_a*in_b.
REQ-019 Approximate result SHALL be S + (V with bits [TRUNC-1:0] cleared); no overflow beyond 2N bits is possible and none SHALL be handled.
REQ-020 OR-only result SHALL be S.
REQ-021 Mode SHALL be captured with the operands at acceptance; mode changes never affect in-flight transactions.
REQ-022 Pipeline SHALL have two register stages: stage 1 holds S, V, SUM_E, mode; stage 2 holds out_p and a mismatch flag (out_p != exact).
REQ-023 Advance rules: stage 2 loads when !out_valid or out_ready; stage 1 loads when stage 1 is empty or stage 2 loads; in_ready SHALL equal the stage-1 load condition.
REQ-024 Transaction accepted (in_valid & in_ready) at edge k SHALL present out_valid at edge k+2 when out_ready is held high; throughput one result per cycle.
REQ-025 Under backpressure (out_valid & !out_ready), out_p SHALL hold stable; no transaction SHALL be dropped, duplicated or reordered.
REQ-026 in_valid high with in_ready low SHALL NOT be captured.
REQ-027 err_cnt SHALL increment by 1 on each output handshake (out_valid & out_ready) whose mismatch flag is set; saturates at 0xFFFF.
REQ-028 cnt_clr SHALL set err_cnt to 0 on the next edge, taking priority over a simultaneous increment.

Reset
REQ-029 With rst high at an edge: both stage valids 0, out_valid 0, err_cnt 0, out_p 0; in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight transactions with no output handshake.

Verification
REQ-031 N=8, TRUNC=4, mode 00, a=0xFF, b=0xFF -> out_p=0xFE01 two cycles after acceptance; err_cnt unchanged.
REQ-032 N=8, TRUNC=4, mode 01, a=0x33, b=0x33 -> S=0x777, V=0x272, out_p=0x9E7 (exact 0xA29); err_cnt increments to 1 on handshake.
REQ-033 N=8, mode 01, a=0x30, b=0x30 -> out_p=0x900 (equals exact); err_cnt unchanged; mode 10 same operands -> out_p=0x700, err_cnt +1.
REQ-034 Stream 6 back-to-back transactions, out_ready low for 3 cycles mid-stream -> in_ready drops after pipeline fills, out_p held stable, all 6 results delivered in order.
REQ-035 Preload err_cnt to 0xFFFF via mismatching results, one more mismatch -> remains 0xFFFF; cnt_clr with simultaneous mismatch handshake -> 0.
REQ-036 rst pulsed with both stages valid -> out_valid 0 next cycle, err_cnt 0, no stale result emitted afterward.
